// File: rtl/spram_ctrl_pkg.sv
// Shared encodings for the single-port RAM access controller.
package spram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

endpackage

// File: rtl/spram_clear_seq.sv
// Full-memory clear sequencer: owns the CLEAR/IDLE state, the clear address
// counter and the busy/done indications.
module spram_clear_seq
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              idle_c
);

  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes only run while busy_q is set, so the first post-reset cycle is quiet.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        busy_d = 1'b1;
        if (busy_q) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign clear_addr = cnt_q;
  assign idle_c     = (state_q == ST_IDLE);

endmodule

// File: rtl/spram_access_ctrl.sv
// Single-port RAM initiator: arbitrates video scan reads and CPU accesses onto
// one spram port, captures q one cycle after each grant, and runs memory clears.
module spram_access_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       DATA_W         = 8,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter int unsigned       CPU_MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dout,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned       WAIT_W   = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  logic              idle_c;
  logic [ADDR_W-1:0] clear_addr;

  logic              cpu_elig_c, grant_cpu_c, grant_vid_c;
  logic [DATA_W-1:0] data_c;
  logic              wren_c;

  tag_e              tag_q, tag_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

  spram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .clear_addr  (clear_addr),
    .idle_c      (idle_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= TAG_NONE;
      wait_q     <= '0;
      addr_q     <= '0;
      cpu_wr_q   <= 1'b0;
      wdata_q    <= '0;
      vid_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      tag_q      <= tag_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      cpu_wr_q   <= cpu_wr_d;
      wdata_q    <= wdata_d;
      vid_hold_q <= vid_hold_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  // Grant: starved CPU first, then video, then CPU; never re-grant CPU in its ack cycle.
  always_comb begin
    cpu_elig_c  = cpu_req && (tag_q != TAG_CPU);
    grant_cpu_c = 1'b0;
    grant_vid_c = 1'b0;
    if (idle_c) begin
      if (cpu_elig_c && ((wait_q == WAIT_MAX) || !vid_req)) begin
        grant_cpu_c = 1'b1;
      end else if (vid_req) begin
        grant_vid_c = 1'b1;
      end
    end
  end

  always_comb begin
    addr_d   = addr_q;
    data_c   = '0;
    wren_c   = 1'b0;
    tag_d    = TAG_NONE;
    wait_d   = wait_q;
    cpu_wr_d = cpu_wr_q;
    wdata_d  = wdata_q;

    if (clear_busy) begin
      addr_d = clear_addr;
      data_c = CLEAR_VALUE;
      wren_c = 1'b1;
    end else if (grant_cpu_c) begin
      addr_d   = cpu_addr;
      data_c   = cpu_din;
      wren_c   = cpu_we;
      tag_d    = TAG_CPU;
      cpu_wr_d = cpu_we;
      wdata_d  = cpu_din;
    end else if (grant_vid_c) begin
      addr_d = vid_addr;
      tag_d  = TAG_VID;
    end

    if (!cpu_req || grant_cpu_c) begin
      wait_d = '0;
    end else if (cpu_elig_c && grant_vid_c && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign ram_address = addr_d;
  assign ram_data    = data_c;
  assign ram_wren    = wren_c;

  // A CPU write returns the word it wrote, independent of the macro's read-during-write behaviour.
  assign vid_valid = (tag_q == TAG_VID);
  assign cpu_ack   = (tag_q == TAG_CPU);
  assign vid_dout  = vid_valid ? ram_q : vid_hold_q;
  assign cpu_dout  = cpu_ack ? (cpu_wr_q ? wdata_q : ram_q) : cpu_hold_q;

  always_comb begin
    vid_hold_d = vid_dout;
    cpu_hold_d = cpu_dout;
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Self-checking bench for spram_access_ctrl with a behavioural 1-cycle-latency spram.
module tb_spram_access_ctrl;

  localparam int unsigned DEPTH   = 16;
  localparam logic [7:0]  CLR_VAL = 8'h5A;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_start = 1'b0;
  logic       clear_busy, clear_done;
  logic       vid_req = 1'b0;
  logic [3:0] vid_addr = '0;
  logic       vid_valid;
  logic [7:0] vid_dout;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_ack;
  logic [7:0] cpu_dout;
  logic [3:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;

  logic [7:0] ram_mem [DEPTH];
  logic [7:0] shadow  [DEPTH];
  logic [7:0] exp_cpu [$];
  int         n_checks = 0;
  int         n_pass = 0;

  spram_access_ctrl #(
    .ADDR_W         (4),
    .DATA_W         (8),
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (CLR_VAL),
    .CPU_MAX_WAIT   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_valid   (vid_valid),
    .vid_dout    (vid_dout),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_ack     (cpu_ack),
    .cpu_dout    (cpu_dout),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural spram: registered q, old data on read-during-write.
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Observes one clear run; stops one cycle after clear_done.
  task automatic run_clear(output int busy_cnt, output int done_cnt,
                           output int addr_err, output int first_addr);
    int  exp_addr;
    bit  seen_done;
    exp_addr   = 0;
    seen_done  = 1'b0;
    busy_cnt   = 0;
    done_cnt   = 0;
    addr_err   = 0;
    first_addr = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clear_busy) begin
        if (first_addr < 0) first_addr = int'(ram_address);
        if (ram_wren !== 1'b1 || ram_address !== 4'(exp_addr) || ram_data !== CLR_VAL)
          addr_err++;
        exp_addr++;
        busy_cnt++;
      end
      if (clear_done) done_cnt++;
      if (seen_done) break;
      if (clear_done) seen_done = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) shadow[k] = CLR_VAL;
  endtask

  // Drives one CPU access, pushes its expected result, waits for the ack.
  task automatic cpu_op(input logic we, input logic [3:0] addr, input logic [7:0] din,
                        output logic [7:0] got, output int lat, output logic [12:0] bus);
    exp_cpu.push_back(we ? din : shadow[addr]);
    if (we) shadow[addr] = din;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    #1;
    bus = {ram_wren, ram_address, ram_data};
    got = 'x;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = cpu_dout;
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({clear_busy, clear_done, vid_valid, cpu_ack, ram_wren} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {clear_busy, clear_done, vid_valid, cpu_ack, ram_wren});
    else n_pass++;
    n_checks++;
    if (ram_address !== 4'h0) $display("FAIL reset_addr: got %h want 0", ram_address);
    else n_pass++;
    n_checks++;
    if ({cpu_dout, vid_dout} !== 16'h0)
      $display("FAIL reset_dout: got %h want 0000", {cpu_dout, vid_dout});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_clear_after_reset();
    int busy_cnt, done_cnt, addr_err, first_addr;
    run_clear(busy_cnt, done_cnt, addr_err, first_addr);
    n_checks++;
    if (busy_cnt != 16) $display("FAIL clr_busy_cycles: got %0d want 16", busy_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL clr_done_pulses: got %0d want 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (addr_err != 0) $display("FAIL clr_write_seq: got %0d bad writes want 0", addr_err);
    else n_pass++;
    n_checks++;
    if (first_addr != 0) $display("FAIL clr_first_addr: got %0d want 0", first_addr);
    else n_pass++;
  endtask

  task automatic test_cpu_read_cleared();
    logic [7:0]  got, exp;
    int          lat;
    logic [12:0] bus;
    @(negedge clk);
    cpu_op(1'b0, 4'd9, 8'h00, got, lat, bus);
    exp = exp_cpu.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL cleared_read: got %h want %h", got, exp);
    else n_pass++;
    n_checks++;
    if (lat != 1) $display("FAIL cleared_read_lat: got %0d want 1", lat);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [7:0]  got, exp;
    int          lat;
    logic [12:0] bus;
    @(negedge clk);
    cpu_op(1'b1, 4'd3, 8'hC3, got, lat, bus);
    exp = exp_cpu.pop_front();
    n_checks++;
    if (bus !== {1'b1, 4'd3, 8'hC3}) $display("FAIL wr_bus: got %h want %h", bus, {1'b1, 4'd3, 8'hC3});
    else n_pass++;
    n_checks++;
    if (got !== exp || lat != 1)
      $display("FAIL wr_ack: got %h lat %0d want %h lat 1", got, lat, exp);
    else n_pass++;
    @(negedge clk);
    cpu_op(1'b0, 4'd3, 8'h00, got, lat, bus);
    exp = exp_cpu.pop_front();
    n_checks++;
    if (bus[12] !== 1'b0 || bus[11:8] !== 4'd3)
      $display("FAIL rd_bus: got wren %b addr %h want 0 3", bus[12], bus[11:8]);
    else n_pass++;
    n_checks++;
    if (got !== exp || lat != 1)
      $display("FAIL rd_ack: got %h lat %0d want %h lat 1", got, lat, exp);
    else n_pass++;
  endtask

  task automatic test_starvation();
    logic [7:0] vv, exp;
    int         ack_at;
    @(negedge clk);
    vid_req  = 1'b1;
    vid_addr = 4'd5;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'd3;
    exp_cpu.push_back(shadow[3]);
    vv     = '0;
    ack_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vv[i-1] = vid_valid;
      if (vid_valid) begin
        n_checks++;
        if (vid_dout !== shadow[5]) $display("FAIL vid_data: got %h want %h", vid_dout, shadow[5]);
        else n_pass++;
      end
      if (cpu_ack) begin
        ack_at = i;
        exp = exp_cpu.pop_front();
        n_checks++;
        if (cpu_dout !== exp) $display("FAIL starve_data: got %h want %h", cpu_dout, exp);
        else n_pass++;
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    n_checks++;
    if (ack_at != 5) $display("FAIL starve_ack_cycle: got %0d want 5", ack_at);
    else n_pass++;
    n_checks++;
    if (vv !== 8'b1110_1111) $display("FAIL vid_valid_gap: got %b want 11101111", vv);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] acks;
    logic [7:0] exp;
    int         n_ack;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'd3;
    exp_cpu.push_back(shadow[3]);
    acks  = '0;
    n_ack = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      acks[i-1] = cpu_ack;
      if (cpu_ack) begin
        exp = exp_cpu.pop_front();
        n_checks++;
        if (cpu_dout !== exp) $display("FAIL b2b_data%0d: got %h want %h", n_ack, cpu_dout, exp);
        else n_pass++;
        n_ack++;
        if (n_ack == 1) begin
          cpu_addr = 4'd9;
          exp_cpu.push_back(shadow[9]);
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    n_checks++;
    if (acks !== 6'b000101) $display("FAIL b2b_ack_pattern: got %b want 000101", acks);
    else n_pass++;
  endtask

  task automatic test_clear_during_read();
    logic [7:0]  got, exp;
    int          lat, done_at, ack_at;
    logic [12:0] bus;
    @(negedge clk);
    cpu_op(1'b1, 4'd7, 8'h77, got, lat, bus);
    exp = exp_cpu.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL pre_clear_write: got %h want %h", got, exp);
    else n_pass++;
    @(negedge clk);
    cpu_req     = 1'b1;
    cpu_we      = 1'b0;
    cpu_addr    = 4'd7;
    clear_start = 1'b1;
    exp_cpu.push_back(shadow[7]);
    @(negedge clk);
    clear_start = 1'b0;
    exp = exp_cpu.pop_front();
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_dout !== exp)
      $display("FAIL inflight_ack: got ack %b data %h want 1 %h", cpu_ack, cpu_dout, exp);
    else n_pass++;
    n_checks++;
    if (clear_busy !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 4'd0)
      $display("FAIL clear_start_bus: got busy %b wren %b addr %h want 1 1 0",
               clear_busy, ram_wren, ram_address);
    else n_pass++;
    for (int k = 0; k < DEPTH; k++) shadow[k] = CLR_VAL;
    exp_cpu.push_back(shadow[7]);
    done_at = -1;
    ack_at  = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (clear_done) done_at = i;
      if (cpu_ack) begin
        ack_at = i;
        got = cpu_dout;
        break;
      end
    end
    cpu_req = 1'b0;
    exp = exp_cpu.pop_front();
    n_checks++;
    if (done_at != 16) $display("FAIL clear2_done_cycle: got %0d want 16", done_at);
    else n_pass++;
    n_checks++;
    if (ack_at != 17) $display("FAIL wait_for_clear: got ack at %0d want 17", ack_at);
    else n_pass++;
    n_checks++;
    if (got !== exp) $display("FAIL post_clear_read: got %h want %h", got, exp);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int busy_cnt, done_cnt, addr_err, first_addr;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 4'd3;
    @(posedge clk);
    #1;
    n_checks++;
    if (cpu_ack !== 1'b1) $display("FAIL inflight_pre_reset: got ack %b want 1", cpu_ack);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_dout !== 8'h00 || clear_busy !== 1'b0)
      $display("FAIL inflight_discard: got ack %b dout %h busy %b want 0 00 0",
               cpu_ack, cpu_dout, clear_busy);
    else n_pass++;
    @(negedge clk);
    reset   = 1'b0;
    cpu_req = 1'b0;
    run_clear(busy_cnt, done_cnt, addr_err, first_addr);
    n_checks++;
    if (busy_cnt != 16 || done_cnt != 1 || addr_err != 0)
      $display("FAIL reclear_after_discard: got busy %0d done %0d err %0d want 16 1 0",
               busy_cnt, done_cnt, addr_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt, done_cnt, addr_err, first_addr;
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (clear_busy && ram_address == 4'd7) break;
      @(negedge clk);
    end
    n_checks++;
    if (clear_busy !== 1'b1 || ram_address !== 4'd7)
      $display("FAIL reach_addr7: got busy %b addr %h want 1 7", clear_busy, ram_address);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({clear_busy, clear_done, ram_wren} !== 3'b000 || ram_address !== 4'd0)
      $display("FAIL async_reset_outs: got flags %b addr %h want 000 0",
               {clear_busy, clear_done, ram_wren}, ram_address);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    run_clear(busy_cnt, done_cnt, addr_err, first_addr);
    n_checks++;
    if (first_addr != 0) $display("FAIL restart_addr: got %0d want 0", first_addr);
    else n_pass++;
    n_checks++;
    if (busy_cnt != 16 || done_cnt != 1 || addr_err != 0)
      $display("FAIL restart_clear: got busy %0d done %0d err %0d want 16 1 0",
               busy_cnt, done_cnt, addr_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clear_after_reset();
    test_cpu_read_cleared();
    test_write_read();
    test_starvation();
    test_back_to_back();
    test_clear_during_read();
    test_reset_inflight();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
